// File: rtl/output_port.sv
// Router output port: round-robin arbitration over crossbar requests, a small flit FIFO,
// and a credit-throttled link driver.
package router_pkg;
  localparam int unsigned ROUTER_PORTS = 5;

  typedef enum logic [1:0] {
    HEAD_FLIT      = 2'd0,
    BODY_FLIT      = 2'd1,
    TAIL_FLIT      = 2'd2,
    HEAD_TAIL_FLIT = 2'd3
  } flit_type_t;

  typedef struct packed {
    flit_type_t  flit_type;
    logic [2:0]  dst;
    logic [26:0] payload;
  } router_pipeline_bus_t;
endpackage

module output_port #(
  parameter int unsigned NUM_OF_PORTS = router_pkg::ROUTER_PORTS,
  parameter int unsigned PORT_ID      = 0,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned CREDITS      = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_OF_PORTS-1:0]           i_outport_req,
  output logic [NUM_OF_PORTS-1:0]           o_outport_ack,
  input  logic                              i_valid,
  input  router_pkg::router_pipeline_bus_t  i_s2o,
  input  logic                              i_is_tail,
  output logic                              o_valid,
  output router_pkg::router_pipeline_bus_t  o_flit,
  input  logic                              i_credit_return,
  output logic                              o_busy,
  output logic                              o_overflow,
  output logic [2:0]                        o_port_id
);
  localparam int unsigned PW  = (NUM_OF_PORTS > 1) ? $clog2(NUM_OF_PORTS) : 1;
  localparam int unsigned AW  = $clog2(FIFO_DEPTH);
  localparam int unsigned CW  = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned CRW = $clog2(CREDITS + 1);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t                           state, state_nxt;
  logic [PW-1:0]                    rr_ptr, rr_ptr_nxt;
  logic [PW-1:0]                    owner, owner_nxt;
  logic                             ack_pulse, ack_pulse_nxt;
  logic [PW-1:0]                    winner_c;
  logic                             found_c;

  router_pkg::router_pipeline_bus_t mem [FIFO_DEPTH];
  logic [AW-1:0]                    rd_ptr, wr_ptr;
  logic [CW-1:0]                    count;
  logic [CRW-1:0]                   credit_cnt;
  logic                             fifo_full_c, pop_c, push_c, drop_c;

  assign fifo_full_c = (count == CW'(FIFO_DEPTH));
  assign pop_c       = (count != '0) && (credit_cnt != '0);
  // A same-cycle pop frees the slot, so a push into a full FIFO still lands
  assign push_c      = i_valid && (!fifo_full_c || pop_c);
  assign drop_c      = i_valid && fifo_full_c && !pop_c;

  assign o_busy        = (state == LOCKED);
  assign o_outport_ack = ack_pulse ? (NUM_OF_PORTS'(1) << owner) : '0;
  assign o_port_id     = 3'(PORT_ID);

  // Round-robin search: first requester at or above rr_ptr, wrapping
  always_comb begin
    winner_c = '0;
    found_c  = 1'b0;
    for (int unsigned i = 0; i < NUM_OF_PORTS; i++) begin
      if (!found_c && i_outport_req[PW'((32'(rr_ptr) + i) % NUM_OF_PORTS)]) begin
        winner_c = PW'((32'(rr_ptr) + i) % NUM_OF_PORTS);
        found_c  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      owner     <= '0;
      ack_pulse <= 1'b0;
    end else begin
      state     <= state_nxt;
      rr_ptr    <= rr_ptr_nxt;
      owner     <= owner_nxt;
      ack_pulse <= ack_pulse_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    rr_ptr_nxt    = rr_ptr;
    owner_nxt     = owner;
    ack_pulse_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (found_c && !fifo_full_c) begin
          state_nxt     = LOCKED;
          owner_nxt     = winner_c;
          ack_pulse_nxt = 1'b1;
          rr_ptr_nxt    = (winner_c == PW'(NUM_OF_PORTS - 1)) ? '0 : winner_c + PW'(1);
        end
      end
      LOCKED: begin
        // A tail releases the lock even when it is dropped on overflow
        if (i_valid && i_is_tail) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push_c) mem[wr_ptr] <= i_s2o;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      credit_cnt <= CRW'(CREDITS);
      o_valid    <= 1'b0;
      o_flit     <= '0;
      o_overflow <= 1'b0;
    end else begin
      if (push_c) wr_ptr <= wr_ptr + AW'(1);
      if (pop_c) begin
        rd_ptr  <= rd_ptr + AW'(1);
        o_flit  <= mem[rd_ptr];
        o_valid <= 1'b1;
      end else begin
        o_flit  <= '0;
        o_valid <= 1'b0;
      end
      count <= count + CW'(push_c) - CW'(pop_c);
      if (pop_c && !i_credit_return) begin
        credit_cnt <= credit_cnt - CRW'(1);
      end else if (!pop_c && i_credit_return && (credit_cnt != CRW'(CREDITS))) begin
        credit_cnt <= credit_cnt + CRW'(1);
      end
      if (drop_c) o_overflow <= 1'b1;
    end
  end
endmodule

// File: doc/output_port.md
Name: output_port

Overview:
- Per-output-port stage directly downstream of the crossbar switch. One instance per router output, five per router.
- Arbitrates the switch's per-input requests for this output and returns a one-hot ack. The port stays locked to the winning input until that packet's tail flit passes.
- Buffers switched flits in a small FIFO and drives the outgoing link under credit-based flow control.

Parameters:
- NUM_OF_PORTS, 5, number of router inputs that can request this output (router_pkg value).
- PORT_ID, 0, index of this output port; informational only, driven onto o_port_id.
- FIFO_DEPTH, 4, output FIFO entries; power of two, >=2.
- CREDITS, 4, initial and maximum downstream buffer credits.

Ports:
- clk  in  1  single clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- i_outport_req  in  NUM_OF_PORTS  bit k = input k requests this output.
- o_outport_ack  out  NUM_OF_PORTS  one-hot grant to input k; one-cycle pulse.
- i_valid  in  1  i_s2o carries a flit this cycle.
- i_s2o  in  router_pipeline_bus_t  switched flit from the crossbar.
- i_is_tail  in  1  the flit on i_s2o is a TAIL_FLIT.
- o_valid  out  1  o_flit is valid on the link.
- o_flit  out  router_pipeline_bus_t  flit to the link / neighbour router.
- i_credit_return  in  1  the downstream router freed one buffer slot.
- o_busy  out  1  port is LOCKED.
- o_overflow  out  1  sticky error: a flit arrived while the FIFO was full.
- o_port_id  out  3  constant PORT_ID.

Behaviour:
- Reset values (sync, rst=1 at posedge): state=IDLE, rr_ptr=0, owner=0, FIFO empty (rd/wr pointers 0, count 0), credit_cnt=CREDITS. Outputs: o_outport_ack=0, o_valid=0, o_flit=0, o_busy=0, o_overflow=0.
- Reset mid-packet: in-flight FIFO contents are discarded and the lock is released. No ack or flit is emitted in the reset cycle.

FSM IDLE:
- Grant condition: i_outport_req!=0 AND fifo count<FIFO_DEPTH.
- Round-robin winner: the first set bit at or above rr_ptr, wrapping from NUM_OF_PORTS-1 to 0.
- Next cycle: o_outport_ack=onehot(winner) for exactly one cycle; owner=winner; rr_ptr=(winner+1) mod NUM_OF_PORTS; state=LOCKED.
- Requests from non-winners are ignored; they must persist to compete again.

FSM LOCKED:
- o_busy=1, o_outport_ack=0, requests ignored.
- Each cycle with i_valid=1 pushes i_s2o into the FIFO.
- A push with i_is_tail=1 returns state to IDLE in the next cycle. Earliest re-grant is the cycle after that, giving a one-cycle bubble.
- Single-flit packet: head and tail in the same flit returns to IDLE after that push.

Flits in IDLE:
- i_valid while IDLE is a protocol error. The flit is still pushed if space exists; the state does not change.

Overflow:
- A push attempt when count==FIFO_DEPTH drops the flit and sets o_overflow.
- o_overflow clears only on rst.
- A tail flit dropped this way still releases the lock.

Output side:
- Pop when FIFO non-empty AND credit_cnt>0.
- Popped entry is registered onto o_flit with o_valid=1 in the next cycle; otherwise o_valid=0 and o_flit=0.
- Latency from an i_valid push into an empty FIFO with credits available to o_valid is 2 cycles.

Simultaneous FIFO push and pop:
- Permitted in the same cycle when count is between 1 and FIFO_DEPTH-1; count is unchanged.
- At count==FIFO_DEPTH, a same-cycle pop frees space, so the push succeeds and no overflow occurs.
- At count==0, the push lands and pops next cycle; there is no bypass.

Credits:
- Each pop decrements credit_cnt; each i_credit_return increments it.
- Pop and return in the same cycle leave credit_cnt unchanged.
- A return at credit_cnt==CREDITS saturates and is ignored.
- At credit_cnt==0 the FIFO holds its contents, and upstream stalls via the FIFO-full check.

Widths and pointers:
- credit_cnt is clog2(CREDITS+1) bits.
- FIFO pointers are clog2(FIFO_DEPTH) bits and wrap naturally; count is clog2(FIFO_DEPTH)+1 bits.

Test Plan:
1. Reset then idle: hold rst=1 for 2 cycles, release with no stimulus → o_valid=0, o_outport_ack=0, o_busy=0, o_overflow=0, credit_cnt=4.
2. Single packet: req=5'b00100, then head, body, tail on consecutive cycles → ack=5'b00100 one cycle later for one cycle. o_valid shows the 3 flits in order, first 2 cycles after the head push. o_busy drops the cycle after the tail push.
3. Round-robin fairness: req=5'b10011 held; complete a 1-flit packet after each grant → ack sequence 00001, 00010, 10000, 00001.
4. Credit stall: CREDITS=4, send a 6-flit packet with no i_credit_return → exactly 4 flits emitted. Then pulse i_credit_return twice → the remaining 2 flits emitted, credit_cnt ends at 0.
5. Overflow: credits=0, push 5 flits into a 4-deep FIFO → 5th flit dropped, o_overflow=1 and stays 1. After returning 4 credits, only 4 flits are emitted.
6. Mid-packet reset: assert rst for 1 cycle after 2 of 4 flits → o_busy=0 and FIFO empty next cycle. The next req is granted with rr_ptr starting at 0.
